mips_mem_arbiter: RTL and testbench
===================================

Name: mips_mem_arbiter

Overview:
- Shares the CPU's single Avalon-style memory port between two requesters: instruction fetch (FETCH state) and data load/store (EXEC1/EXEC2).
- Registers the bus strobes, holds them stable through waitrequest, captures readdata and returns a one-cycle done pulse to the winning requester.
- Fixed priority to data, with a starvation guard so fetch is always eventually served.

Parameters:
- DATA_W, 32, width of bus data and requester data.
- ADDR_W, 32, width of all addresses.
- STARVE_LIMIT, 4, maximum consecutive data grants while a fetch request is pending (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; level, held until i_done.
- i_addr  in  ADDR_W  fetch address.
- i_done  out  1  one-cycle pulse: fetch complete.
- i_rdata  out  DATA_W  fetched word; valid in the i_done cycle and held until the next fetch completes.
- d_req  in  1  data request; level, held until d_done.
- d_write  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_byteenable  in  4  data byte lanes.
- d_wdata  in  DATA_W  store data.
- d_done  out  1  one-cycle pulse: data access complete.
- d_rdata  out  DATA_W  load data; valid in the d_done cycle and held until the next load completes.
- d_err  out  1  alignment error; pulses with d_done (optional feature only).
- address  out  ADDR_W  bus address.
- read  out  1  bus read strobe.
- write  out  1  bus write strobe.
- byteenable  out  4  bus byte enables.
- writedata  out  DATA_W  bus write data.
- readdata  in  DATA_W  bus read data.
- waitrequest  in  1  bus stall.
- busy  out  1  high in BUS_I and BUS_D.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; read, write, i_done, d_done, d_err, busy = 0.
  - address, writedata, i_rdata, d_rdata = 0; byteenable = 4'b0000.
  - Starvation counter = 0.
  - Any in-flight transaction is dropped; no done pulse is issued for it.
- States:
  - IDLE: no bus strobes.
  - BUS_I: fetch transaction.
  - BUS_D: data transaction.
- Grant, evaluated at each rising edge in IDLE:
  - d_req only: BUS_D.
  - i_req only: BUS_I.
  - Both: BUS_D unless the counter equals STARVE_LIMIT, in which case BUS_I.
  - Neither: stay in IDLE.
- On grant, the requester's payload is registered onto the bus; the requester may change its payload afterwards.
  - Fetch: read = 1, byteenable = 4'b1111.
  - Data: read = !d_write, write = d_write, byteenable = d_byteenable, writedata = d_wdata.
- Strobes, address, byteenable and writedata stay constant while waitrequest = 1.
- Completion is the first rising edge in BUS_x with waitrequest = 0. At that edge:
  - read and write drop to 0.
  - On a read, readdata is captured into i_rdata or d_rdata.
  - The matching done output is high for exactly the following cycle.
  - State returns to IDLE.
- Minimum latency: request sampled at edge 0 → strobe high in cycle 1 → done in cycle 2. Each extra waitrequest cycle adds 1.
- Bus idle gap: at least one cycle with read = write = 0 between consecutive transactions.
- Starvation counter:
  - Increments on a data grant made while i_req = 1.
  - Cleared on any fetch grant and whenever i_req = 0 in IDLE.
  - Saturates at STARVE_LIMIT.
- A store completion never changes d_rdata.
- Requests are levels. A requester re-requesting in its own done cycle is sampled normally at the next IDLE edge.
- If a requester deasserts req before its done, the transaction still completes and the done pulse is still issued.
- read and write are never high simultaneously.
- Halt or pc == 0 handling stays in the decoder; the arbiter ignores it.

Optional Feature:
- Macro: MIPS_MEM_ALIGN_CHECK_EN.
- Defined:
  - A data grant is misaligned when d_byteenable == 4'b1111 with d_addr[1:0] != 0, or d_byteenable ∈ {4'b0011, 4'b1100} with d_addr[0] != 0.
  - A misaligned grant skips the bus: BUS_D issues no strobe, and d_done and d_err pulse together one cycle after the grant edge.
  - d_rdata is unchanged; the starvation counter is still updated.
- Undefined: addresses pass straight to the bus and d_err is tied to 0.

Test Plan:
- Fetch, zero wait: reset_n 0→1; i_req = 1, i_addr = 0xBFC00000, waitrequest = 0, readdata = 0x24020005 → read = 1 with address 0xBFC00000 in cycle 1; i_done = 1 with i_rdata = 0x24020005 in cycle 2.
- Store, 3 waitrequest cycles: d_req = 1, d_write = 1, d_addr = 0x1000, d_wdata = 0xDEADBEEF, d_byteenable = 4'b1111 → write held 4 cycles with stable signals; d_done 1 cycle later; read never high.
- Starvation: i_req and d_req held high with STARVE_LIMIT = 4 → grant order D, D, D, D, I, D…; i_done asserted by the fifth transaction.
- Reset mid-transaction: reset_n low while BUS_D and waitrequest = 1 → read, write, d_done = 0 immediately; after release with no requests, the bus stays idle.
- Store then load to the same requester: d_rdata changes only on the load's d_done (readdata = 0x12345678), not on the store's d_done.
- With MIPS_MEM_ALIGN_CHECK_EN: d_addr = 0x1002, byteenable = 4'b1111 → no read or write strobe; d_done = d_err = 1 in cycle 2. Without the macro: a bus read is issued to 0x1002.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto one Avalon-style memory port, data-priority with a
// starvation guard for fetch. Define MIPS_MEM_ALIGN_CHECK_EN to enable data alignment checking.
module mips_mem_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_byteenable,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [3:0]        byteenable,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  input  logic              waitrequest,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StBusI, StBusD} state_e;

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  state_e     state;
  logic [3:0] starve_cnt;
  logic       fetch_wins;
  logic       misaligned;
  logic       skip;

  // Data wins a tie unless fetch has already waited out STARVE_LIMIT data grants.
  assign fetch_wins = i_req && (!d_req || (starve_cnt == Limit));
  assign busy       = (state != StIdle);

`ifdef MIPS_MEM_ALIGN_CHECK_EN
  logic skip_q;
  logic err_q;

  always_comb begin
    misaligned = 1'b0;
    if (d_byteenable == 4'b1111) begin
      misaligned = (d_addr[1:0] != 2'b00);
    end else if ((d_byteenable == 4'b0011) || (d_byteenable == 4'b1100)) begin
      misaligned = d_addr[0];
    end
  end

  assign skip  = skip_q;
  assign d_err = err_q;
`else
  assign misaligned = 1'b0;
  assign skip       = 1'b0;
  assign d_err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= StIdle;
      starve_cnt <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      byteenable <= 4'b0000;
      writedata  <= '0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
`ifdef MIPS_MEM_ALIGN_CHECK_EN
      skip_q     <= 1'b0;
      err_q      <= 1'b0;
`endif
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
`ifdef MIPS_MEM_ALIGN_CHECK_EN
      err_q  <= 1'b0;
`endif
      unique case (state)
        StIdle: begin
          if (!i_req) starve_cnt <= '0;
          if (fetch_wins) begin
            state      <= StBusI;
            read       <= 1'b1;
            write      <= 1'b0;
            address    <= i_addr;
            byteenable <= 4'b1111;
            starve_cnt <= '0;
          end else if (d_req) begin
            state      <= StBusD;
            // A misaligned access is completed internally without touching the bus.
            read       <= !d_write && !misaligned;
            write      <= d_write && !misaligned;
            address    <= d_addr;
            byteenable <= d_byteenable;
            writedata  <= d_wdata;
            if (i_req && (starve_cnt != Limit)) starve_cnt <= starve_cnt + 4'd1;
`ifdef MIPS_MEM_ALIGN_CHECK_EN
            skip_q     <= misaligned;
`endif
          end
        end
        StBusI: begin
          if (!waitrequest) begin
            read    <= 1'b0;
            i_rdata <= readdata;
            i_done  <= 1'b1;
            state   <= StIdle;
          end
        end
        StBusD: begin
          if (!waitrequest || skip) begin
            read   <= 1'b0;
            write  <= 1'b0;
            if (read) d_rdata <= readdata;
            d_done <= 1'b1;
            state  <= StIdle;
`ifdef MIPS_MEM_ALIGN_CHECK_EN
            err_q  <= skip_q;
            skip_q <= 1'b0;
`endif
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter: expected bus transactions and done results are queued
// as stimulus is issued and checked by a monitor as the DUT produces them.
module tb_mips_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [3:0]  d_byteenable = '0;
  logic [31:0] d_wdata = '0;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata = '0;
  logic        waitrequest = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  mips_mem_arbiter #(
    .DATA_W      (32),
    .ADDR_W      (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_done      (i_done),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_write     (d_write),
    .d_addr      (d_addr),
    .d_byteenable(d_byteenable),
    .d_wdata     (d_wdata),
    .d_done      (d_done),
    .d_rdata     (d_rdata),
    .d_err       (d_err),
    .address     (address),
    .read        (read),
    .write       (write),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .busy        (busy)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } dres_t;

  bus_t        bus_q[$];
  dres_t       d_q[$];
  logic [31:0] i_q[$];

  int          total = 0;
  int          bad = 0;
  int          cfg_ws = 0;
  int          last_len = 0;
  logic [31:0] exp_drd = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2402_0005;
    if (a == 32'h0000_2004) return 32'h1234_5678;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic exp_bus(input logic [31:0] a, input logic rd, input logic wr,
                         input logic [3:0] be, input logic [31:0] wd);
    bus_t b;
    b.addr = a; b.rd = rd; b.wr = wr; b.be = be; b.wdata = wd;
    bus_q.push_back(b);
  endtask

  task automatic exp_d(input logic [31:0] rdata, input logic err);
    dres_t r;
    r.rdata = rdata; r.err = err;
    d_q.push_back(r);
  endtask

  // Memory slave: inserts cfg_ws wait states per transaction.
  initial begin
    int  ws_left = 0;
    bit  in_txn = 0;
    forever begin
      @(negedge clk);
      if (read || write) begin
        if (!in_txn) begin
          in_txn = 1;
          ws_left = cfg_ws;
        end
        readdata = mem_rd(address);
        if (ws_left > 0) begin
          waitrequest = 1'b1;
          ws_left--;
        end else begin
          waitrequest = 1'b0;
        end
      end else begin
        in_txn = 0;
        waitrequest = 1'b0;
      end
    end
  end

  // Monitor: bus transactions, strobe stability and done results against the queues.
  initial begin
    bit   active = 0;
    bit   cur_ok = 0;
    int   slen = 0;
    bus_t cur;
    dres_t dr;
    logic [31:0] ir;
    forever begin
      @(posedge clk);
      #1;
      chk("rw_excl", {31'b0, read & write}, 32'd0);
      if (read || write) begin
        if (!active) begin
          active = 1;
          slen = 0;
          cur_ok = (bus_q.size() != 0);
          if (!cur_ok) chk("bus_unexp", 32'd1, 32'd0);
          else cur = bus_q.pop_front();
        end
        if (cur_ok) begin
          chk("bus_addr", address, cur.addr);
          chk("bus_rd", {31'b0, read}, {31'b0, cur.rd});
          chk("bus_wr", {31'b0, write}, {31'b0, cur.wr});
          chk("bus_be", {28'b0, byteenable}, {28'b0, cur.be});
          if (cur.wr) chk("bus_wdata", writedata, cur.wdata);
        end
        slen++;
      end else begin
        if (active) last_len = slen;
        active = 0;
      end
      if (i_done) begin
        if (i_q.size() == 0) chk("i_unexp", 32'd1, 32'd0);
        else begin
          ir = i_q.pop_front();
          chk("i_rdata", i_rdata, ir);
        end
      end
      if (d_done) begin
        if (d_q.size() == 0) chk("d_unexp", 32'd1, 32'd0);
        else begin
          dr = d_q.pop_front();
          chk("d_rdata", d_rdata, dr.rdata);
          chk("d_err", {31'b0, d_err}, {31'b0, dr.err});
        end
      end
    end
  end

  task automatic do_fetch(input logic [31:0] a, input int ws, output int lat);
    @(negedge clk);
    cfg_ws = ws; i_req = 1'b1; i_addr = a;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!i_done && lat < 50);
    if (!i_done) chk("i_timeout", 32'd0, 32'd1);
    @(negedge clk);
    i_req = 1'b0;
    @(posedge clk); #1;
    chk("i_pulse", {31'b0, i_done}, 32'd0);
  endtask

  task automatic do_data(input logic wr, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input int ws, output int lat);
    @(negedge clk);
    cfg_ws = ws; d_req = 1'b1; d_write = wr; d_addr = a; d_byteenable = be; d_wdata = wd;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!d_done && lat < 50);
    if (!d_done) chk("d_timeout", 32'd0, 32'd1);
    @(negedge clk);
    d_req = 1'b0; d_write = 1'b0;
    @(posedge clk); #1;
    chk("d_pulse", {31'b0, d_done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nd;
    int cyc;

    // Reset values
    #3;
    chk("rst_read", {31'b0, read}, 32'd0);
    chk("rst_write", {31'b0, write}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_addr", address, 32'd0);
    chk("rst_be", {28'b0, byteenable}, 32'd0);
    chk("rst_irdata", i_rdata, 32'd0);
    chk("rst_drdata", d_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Fetch, zero wait
    exp_bus(32'hBFC0_0000, 1'b1, 1'b0, 4'hF, 32'd0);
    i_q.push_back(32'h2402_0005);
    do_fetch(32'hBFC0_0000, 0, lat);
    chk("fetch_lat", lat, 32'd2);
    chk("i_rdata_hold", i_rdata, 32'h2402_0005);

    // Store with 3 wait states leaves d_rdata alone
    exp_bus(32'h1000, 1'b0, 1'b1, 4'hF, 32'hDEAD_BEEF);
    exp_d(exp_drd, 1'b0);
    do_data(1'b1, 32'h1000, 4'hF, 32'hDEAD_BEEF, 3, lat);
    chk("store_lat", lat, 32'd5);
    chk("store_len", last_len, 32'd4);

    // Load updates d_rdata, following store does not
    exp_bus(32'h2004, 1'b1, 1'b0, 4'hF, 32'd0);
    exp_drd = 32'h1234_5678;
    exp_d(exp_drd, 1'b0);
    do_data(1'b0, 32'h2004, 4'hF, 32'd0, 1, lat);
    chk("load_lat", lat, 32'd3);
    exp_bus(32'h2008, 1'b0, 1'b1, 4'b0011, 32'h0000_ABCD);
    exp_d(exp_drd, 1'b0);
    do_data(1'b1, 32'h2008, 4'b0011, 32'h0000_ABCD, 0, lat);
    chk("store2_lat", lat, 32'd2);
    chk("d_rdata_hold", d_rdata, 32'h1234_5678);

    // Request dropped after grant still completes
    exp_bus(32'h2010, 1'b1, 1'b0, 4'hF, 32'd0);
    exp_drd = mem_rd(32'h2010);
    exp_d(exp_drd, 1'b0);
    @(negedge clk);
    cfg_ws = 2; d_req = 1'b1; d_write = 1'b0; d_addr = 32'h2010; d_byteenable = 4'hF;
    @(negedge clk);
    d_req = 1'b0;
    cyc = 0;
    while (!d_done && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk("drop_done", {31'b0, d_done}, 32'd1);

    // Starvation guard: D D D D I D D
    for (int k = 0; k < 4; k++) begin
      exp_bus(32'h4000, 1'b1, 1'b0, 4'hF, 32'd0);
      exp_d(mem_rd(32'h4000), 1'b0);
    end
    exp_bus(32'h0040, 1'b1, 1'b0, 4'hF, 32'd0);
    i_q.push_back(mem_rd(32'h0040));
    for (int k = 0; k < 2; k++) begin
      exp_bus(32'h4000, 1'b1, 1'b0, 4'hF, 32'd0);
      exp_d(mem_rd(32'h4000), 1'b0);
    end
    exp_drd = mem_rd(32'h4000);
    @(negedge clk);
    cfg_ws = 0;
    i_req = 1'b1; i_addr = 32'h0040;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h4000; d_byteenable = 4'hF;
    fork
      begin
        int ic = 0;
        while (!i_done && ic < 100) begin
          @(posedge clk); #1; ic++;
        end
        chk("starve_i_done", {31'b0, i_done}, 32'd1);
        @(negedge clk);
        i_req = 1'b0;
      end
      begin
        nd = 0;
        cyc = 0;
        while (nd < 6 && cyc < 200) begin
          @(posedge clk); #1; cyc++;
          if (d_done) nd++;
        end
        chk("starve_d_count", nd, 32'd6);
        @(negedge clk);
        d_req = 1'b0;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("starve_bus_q", bus_q.size(), 32'd0);

    // Misaligned word access
`ifdef MIPS_MEM_ALIGN_CHECK_EN
    exp_d(exp_drd, 1'b1);
`else
    exp_bus(32'h1002, 1'b1, 1'b0, 4'hF, 32'd0);
    exp_drd = mem_rd(32'h1002);
    exp_d(exp_drd, 1'b0);
`endif
    do_data(1'b0, 32'h1002, 4'hF, 32'd0, 0, lat);
    chk("align_lat", lat, 32'd2);

    // Reset in the middle of a stalled data transaction
    exp_bus(32'h5000, 1'b1, 1'b0, 4'hF, 32'd0);
    @(negedge clk);
    cfg_ws = 20; d_req = 1'b1; d_write = 1'b0; d_addr = 32'h5000; d_byteenable = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset_n = 1'b0;
    d_req = 1'b0;
    #1;
    chk("mid_rst_read", {31'b0, read}, 32'd0);
    chk("mid_rst_write", {31'b0, write}, 32'd0);
    chk("mid_rst_done", {31'b0, d_done}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_drdata", d_rdata, 32'd0);
    exp_drd = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("post_rst_idle", {31'b0, read | write | busy}, 32'd0);
    end

    // Recovery after reset
    exp_bus(32'h2004, 1'b1, 1'b0, 4'hF, 32'd0);
    exp_drd = 32'h1234_5678;
    exp_d(exp_drd, 1'b0);
    do_data(1'b0, 32'h2004, 4'hF, 32'd0, 0, lat);
    chk("recover_lat", lat, 32'd2);

    repeat (2) @(posedge clk);
    #1;
    chk("left_bus_q", bus_q.size(), 32'd0);
    chk("left_d_q", d_q.size(), 32'd0);
    chk("left_i_q", i_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
